// File: rtl/dpi_pkg.sv
// -----------------------------------------------------------------------------
// dpi_pkg
// Shared types and constants for the DPI stream sequencer and its stream table.
//   seq_state_t   : sequencer FSM states
//   SID_W_DEFAULT : default stream ID width (table depth is 2**SID_W)
//   DRAIN_MAX     : largest drain length the 3-bit drain counter can hold
// -----------------------------------------------------------------------------
package dpi_pkg;

  localparam int SID_W_DEFAULT = 6;
  localparam int DRAIN_MAX     = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    GAP    = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    EOP    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/dpi_stream_table.sv
// -----------------------------------------------------------------------------
// dpi_stream_table
// Per-stream "seen" and "enable" bits held in two 2**SID_W-bit flop vectors.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset (clears both)
//   lookup_id                : combinational lookup address
//   lookup_seen/lookup_enable: bits stored for lookup_id
//   set_seen, set_id         : mark set_id as seen (end of an enabled packet)
//   cfg_we, cfg_id, cfg_enable: write one enable bit
//   clear_seen               : clear the whole seen vector (beats set_seen)
// -----------------------------------------------------------------------------
module dpi_stream_table
  import dpi_pkg::*;
#(
  parameter int SID_W = SID_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SID_W-1:0] lookup_id,
  output logic             lookup_seen,
  output logic             lookup_enable,
  input  logic             set_seen,
  input  logic [SID_W-1:0] set_id,
  input  logic             cfg_we,
  input  logic [SID_W-1:0] cfg_id,
  input  logic             cfg_enable,
  input  logic             clear_seen
);

  localparam int DEPTH = 1 << SID_W;

  logic [DEPTH-1:0] seen_reg,   seen_next;
  logic [DEPTH-1:0] enable_reg, enable_next;

  // Per-entry next-state; a clear in the same cycle as a set leaves the entry 0.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign seen_next[gi] = clear_seen ? 1'b0 :
                             ((set_seen && (set_id == SID_W'(gi))) ? 1'b1 : seen_reg[gi]);
      assign enable_next[gi] = (cfg_we && (cfg_id == SID_W'(gi))) ? cfg_enable : enable_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_reg   <= '0;
      enable_reg <= '0;
    end else begin
      seen_reg   <= seen_next;
      enable_reg <= enable_next;
    end
  end

  assign lookup_seen   = seen_reg[lookup_id];
  assign lookup_enable = enable_reg[lookup_id];

endmodule

// File: rtl/dpi_stream_sequencer.sv
// -----------------------------------------------------------------------------
// dpi_stream_sequencer
// Sequences tagged packet bytes into the regex matcher bank:
// load_state/new_stream_id, one restore gap, the character stream, a drain
// period, then eop. Tracks seen/enabled streams in dpi_stream_table.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   in_vld/in_rdy/in_data/in_sop/in_eop/in_stream_id : upstream byte stream
//   cfg_we/cfg_stream_id/cfg_enable : enable-mask write
//   cfg_clear_seen                 : clear the seen table
//   load_state, new_stream_id      : packet start pulse and "unseen" flag
//   stream_id, enable              : held from load_state through eop
//   char_in, char_in_vld           : character to matchers
//   eop                            : packet finalise pulse
//   pkt_count                      : completed packets (wraps)
//   proto_err                      : sticky, SOP seen mid-packet
// All outputs except in_rdy come straight from flops.
// -----------------------------------------------------------------------------
module dpi_stream_sequencer
  import dpi_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int SID_W        = SID_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [7:0]       in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [SID_W-1:0] in_stream_id,
  input  logic             cfg_we,
  input  logic [SID_W-1:0] cfg_stream_id,
  input  logic             cfg_enable,
  input  logic             cfg_clear_seen,
  output logic             load_state,
  output logic             new_stream_id,
  output logic [SID_W-1:0] stream_id,
  output logic             enable,
  output logic [7:0]       char_in,
  output logic             char_in_vld,
  output logic             eop,
  output logic [31:0]      pkt_count,
  output logic             proto_err
);

  seq_state_t state_reg, state_next;

  logic [SID_W-1:0] stream_id_reg;
  logic             enable_reg;
  logic             new_stream_id_reg;
  logic             load_state_reg;
  logic [7:0]       char_reg;
  logic             char_vld_reg;
  logic             eop_reg;
  logic [31:0]      pkt_count_reg;
  logic             proto_err_reg;
  logic [2:0]       drain_cnt_reg;
  logic             first_beat_reg;

  logic lookup_seen, lookup_enable;
  logic start_pkt, accept, stray_sop, end_beat;

  assign in_rdy    = (state_reg == STREAM);
  assign accept    = in_vld && in_rdy;
  assign start_pkt = (state_reg == IDLE) && in_vld && in_sop;
  // A SOP after the first beat closes the packet; its byte is discarded.
  assign stray_sop = accept && in_sop && !first_beat_reg;
  assign end_beat  = accept && (in_eop || stray_sop);

  dpi_stream_table #(.SID_W(SID_W)) u_table (
    .clk          (clk),
    .rst          (rst),
    .lookup_id    (in_stream_id),
    .lookup_seen  (lookup_seen),
    .lookup_enable(lookup_enable),
    .set_seen     ((state_reg == EOP) && enable_reg),
    .set_id       (stream_id_reg),
    .cfg_we       (cfg_we),
    .cfg_id       (cfg_stream_id),
    .cfg_enable   (cfg_enable),
    .clear_seen   (cfg_clear_seen)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_pkt) state_next = LOAD;
      LOAD:    state_next = GAP;
      GAP:     state_next = STREAM;
      STREAM:  if (end_beat) state_next = DRAIN;
      // The counter was loaded on the final accept, one cycle before the
      // last char appears, so reaching zero here lands eop exactly
      // DRAIN_CYCLES idle cycles after that char.
      DRAIN:   if (drain_cnt_reg == 3'd0) state_next = EOP;
      EOP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stream_id_reg     <= '0;
      enable_reg        <= 1'b0;
      new_stream_id_reg <= 1'b0;
      load_state_reg    <= 1'b0;
      char_reg          <= '0;
      char_vld_reg      <= 1'b0;
      eop_reg           <= 1'b0;
      pkt_count_reg     <= '0;
      proto_err_reg     <= 1'b0;
      drain_cnt_reg     <= '0;
      first_beat_reg    <= 1'b0;
    end else begin
      load_state_reg <= start_pkt;
      if (start_pkt) begin
        // Latched once; later config writes do not affect this packet.
        stream_id_reg     <= in_stream_id;
        enable_reg        <= lookup_enable;
        new_stream_id_reg <= ~lookup_seen;
      end

      char_vld_reg <= accept && !stray_sop;
      if (accept && !stray_sop) char_reg <= in_data;

      if (state_reg == GAP)  first_beat_reg <= 1'b1;
      else if (accept)       first_beat_reg <= 1'b0;

      if (end_beat)
        drain_cnt_reg <= 3'(DRAIN_CYCLES);
      else if ((state_reg == DRAIN) && (drain_cnt_reg != 3'd0))
        drain_cnt_reg <= drain_cnt_reg - 3'd1;

      eop_reg <= (state_reg == DRAIN) && (drain_cnt_reg == 3'd0);

      if (state_reg == EOP) pkt_count_reg <= pkt_count_reg + 32'd1;
      if (stray_sop)        proto_err_reg <= 1'b1;
    end
  end

  assign load_state    = load_state_reg;
  assign new_stream_id = new_stream_id_reg;
  assign stream_id     = stream_id_reg;
  assign enable        = enable_reg;
  assign char_in       = char_reg;
  assign char_in_vld   = char_vld_reg;
  assign eop           = eop_reg;
  assign pkt_count     = pkt_count_reg;
  assign proto_err     = proto_err_reg;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
`timescale 1ns/1ps
module tb_dpi_stream_sequencer;
  localparam int D  = 2;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic          in_rdy;
  logic [7:0]    in_data = '0;
  logic [SW-1:0] in_stream_id = '0;
  logic          cfg_we = 1'b0, cfg_enable = 1'b0, cfg_clear_seen = 1'b0;
  logic [SW-1:0] cfg_stream_id = '0;
  logic          load_state, new_stream_id, enable, char_in_vld, eop, proto_err;
  logic [SW-1:0] stream_id;
  logic [7:0]    char_in;
  logic [31:0]   pkt_count;

  dpi_stream_sequencer #(.DRAIN_CYCLES(D), .SID_W(SW)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_stream_id(in_stream_id),
    .cfg_we(cfg_we), .cfg_stream_id(cfg_stream_id), .cfg_enable(cfg_enable),
    .cfg_clear_seen(cfg_clear_seen), .load_state(load_state),
    .new_stream_id(new_stream_id), .stream_id(stream_id), .enable(enable),
    .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
    .pkt_count(pkt_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; bit en; bit nw; int cyc; } load_t;
  load_t       load_q[$];
  logic [7:0]  char_q[$];
  bit          eop_q[$];     // 1 = packet closed by a stray SOP

  // Reference model state: which streams are seen/enabled, packets done.
  bit          seen_m[64];
  bit          mask_m[64];
  int unsigned count_m = 0;

  int checks = 0, errors = 0;
  int eop_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : mon
    load_t lx;
    logic [7:0] c;
    bit st, r_edge, in_pkt, first, pend_cnt, cur_en;
    int cur_id, load_cyc, last_char;
    in_pkt = 0; first = 0; pend_cnt = 0; cur_en = 0; cur_id = 0; load_cyc = 0; last_char = 0;
    forever begin
      @(posedge clk);
      r_edge = rst;
      #2;
      if (r_edge) begin
        in_pkt = 0; pend_cnt = 0; first = 0;
        continue;
      end
      if (pend_cnt) begin
        chk("pkt_count", pkt_count, count_m);
        pend_cnt = 0;
      end
      if (load_state) begin
        chk("load_expected", load_q.size() > 0, 1);
        if (load_q.size() > 0) begin
          lx = load_q.pop_front();
          chk("load_cycle", cyc, lx.cyc);
          chk("new_stream_id", new_stream_id, lx.nw);
          cur_id = lx.id; cur_en = lx.en;
          in_pkt = 1; first = 1; load_cyc = cyc;
        end
      end
      if (in_pkt) begin
        chk("stream_id_hold", stream_id, cur_id);
        chk("enable_hold", enable, cur_en);
      end
      if (char_in_vld) begin
        chk("char_expected", char_q.size() > 0, 1);
        if (char_q.size() > 0) begin
          c = char_q.pop_front();
          chk("char_in", char_in, c);
        end
        if (first) begin
          chk("first_char_cycle", cyc, load_cyc + 3);
          first = 0;
        end
        last_char = cyc;
      end
      if (eop) begin
        chk("eop_expected", eop_q.size() > 0, 1);
        if (eop_q.size() > 0) begin
          st = eop_q.pop_front();
          if (!st) chk("eop_cycle", cyc, last_char + D + 1);
          count_m++;
          if (cur_en) seen_m[cur_id] = 1;
          pend_cnt = 1;
        end
        in_pkt = 0;
        eop_cnt++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cfg(input int id, input bit en);
    cfg_we = 1; cfg_stream_id = SW'(id); cfg_enable = en;
    @(posedge clk); #1;
    cfg_we = 0;
    mask_m[id] = en;
  endtask

  task automatic clear_seen();
    cfg_clear_seen = 1;
    @(posedge clk); #1;
    cfg_clear_seen = 0;
    for (int i = 0; i < 64; i++) seen_m[i] = 0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {load_state, new_stream_id, stream_id, enable, char_in, char_in_vld,
               eop, pkt_count, proto_err, in_rdy}, 0);
  endtask

  // gap_mode: 0 back-to-back, 1 random bubbles, 2 fixed 2-cycle bubbles.
  // stray_at: beat index carrying a stray SOP (-1 none).
  // abort_after: reset after this many accepted beats (-1 none).
  task automatic send_pkt(input int id, input int len, input int gap_mode,
                          input int stray_at, input int abort_after);
    load_t lx;
    logic [7:0] b;
    int start, n, gaps;
    start = eop_cnt;
    lx.id = id; lx.en = mask_m[id]; lx.nw = !seen_m[id]; lx.cyc = cyc + 1;
    load_q.push_back(lx);
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        gaps = (gap_mode == 2) ? 2 : (gap_mode == 1) ? int'($urandom_range(0, 2)) : 0;
        in_vld = 0;
        idle(gaps);
      end
      b = 8'($urandom);
      in_vld = 1; in_data = b;
      in_sop = (i == 0) || (i == stray_at);
      in_eop = (i == len - 1) && (i != stray_at);
      in_stream_id = (i == 0) ? SW'(id) : SW'($urandom);
      n = 0;
      do begin @(negedge clk); n++; end while (!in_rdy && n < 20);
      if (!in_rdy) begin
        chk("in_rdy_timeout", in_rdy, 1);
        finish_run();
      end
      if (i == stray_at) eop_q.push_back(1);
      else begin
        char_q.push_back(b);
        if (in_eop) eop_q.push_back(0);
      end
      @(posedge clk); #1;
      in_vld = 0; in_sop = 0; in_eop = 0;
      if (i == abort_after - 1) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check_reset_outputs("reset_mid_packet_outputs");
        for (int k = 0; k < 64; k++) begin seen_m[k] = 0; mask_m[k] = 0; end
        count_m = 0;
        load_q.delete(); eop_q.delete();
        idle(6);
        chk("no_eop_after_abort", eop_cnt, start);
        return;
      end
      if (i == stray_at) break;
    end
    n = 0;
    while (eop_cnt == start && n < 100) begin @(posedge clk); #3; n++; end
    chk("eop_arrived", eop_cnt != start, 1);
    @(posedge clk); #1;
  endtask

  initial begin : drv
    int ids[8];
    int r;
    ids = '{1, 2, 3, 5, 9, 12, 40, 63};
    for (int i = 0; i < 64; i++) begin seen_m[i] = 0; mask_m[i] = 0; end
    idle(3);
    rst = 0;
    check_reset_outputs("reset_outputs");
    idle(1);

    // Stream 5 enabled: first packet new, second not.
    cfg(5, 1);
    send_pkt(5, 4, 0, -1, -1);
    send_pkt(5, 4, 0, -1, -1);
    // Stream 9 disabled: never marked seen.
    send_pkt(9, 3, 0, -1, -1);
    send_pkt(9, 2, 0, -1, -1);
    // Bubbles of 2 cycles between beats.
    send_pkt(5, 5, 2, -1, -1);
    // Single-byte packet.
    cfg(12, 1);
    send_pkt(12, 1, 0, -1, -1);
    send_pkt(12, 1, 0, -1, -1);

    // Randomized traffic with config changes between packets.
    for (int p = 0; p < 24; p++) begin
      r = $urandom_range(0, 9);
      if (r < 3) cfg(ids[$urandom_range(0, 7)], 1'($urandom));
      else if (r == 3) clear_seen();
      idle($urandom_range(0, 2));
      send_pkt(ids[$urandom_range(0, 7)], $urandom_range(1, 8), 1, -1, -1);
    end

    // Stray SOP on beat 3.
    chk("proto_err_before", proto_err, 0);
    cfg(3, 1);
    send_pkt(3, 5, 0, 2, -1);
    chk("proto_err_after", proto_err, 1);
    send_pkt(3, 3, 0, -1, -1);
    chk("proto_err_sticky", proto_err, 1);

    // Reset while streaming, then stream 5 must be new again.
    send_pkt(5, 5, 0, -1, 2);
    cfg(5, 1);
    send_pkt(5, 3, 1, -1, -1);
    send_pkt(5, 2, 0, -1, -1);

    idle(4);
    chk("queues_empty", load_q.size() + char_q.size() + eop_q.size(), 0);
    finish_run();
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dpi_stream_sequencer.md
# dpi_stream_sequencer

Drives the per-stream regex matcher bank of the DPI core and owns the bank's sequencing protocol. Accepts tagged packet bytes from the upstream parser and issues `load_state` and `new_stream_id` before each packet, then the character stream, then `eop` once the matchers have settled. Tracks which stream IDs have been seen and which are enabled, so every matcher saves and restores its state per stream. One instance sits between the parser FIFO and all matcher wrappers, and its outputs fan out to every wrapper.

## Interface
- `DRAIN_CYCLES`, default 2: idle cycles between the last `char_in_vld` and `eop`. Legal range 2..7.
- `SID_W`, default 6: stream ID width. Table depth is 2^SID_W.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_vld` in 1: input byte valid.
- `in_rdy` out 1: input byte accepted when `in_vld & in_rdy`.
- `in_data` in 8: packet byte.
- `in_sop` in 1: first byte of the packet. `in_stream_id` is valid on this beat.
- `in_eop` in 1: last byte of the packet.
- `in_stream_id` in SID_W: stream tag, sampled on the SOP beat.
- `cfg_we` in 1: writes `cfg_enable` into the enable bit selected by `cfg_stream_id`.
- `cfg_stream_id` in SID_W: configuration target.
- `cfg_enable` in 1: enable value to write.
- `cfg_clear_seen` in 1: clears the whole seen table.
- `load_state` out 1: one-cycle pulse that starts a packet.
- `new_stream_id` out 1: the stream has not been seen. Valid with `load_state`.
- `stream_id` out SID_W: held from `load_state` through `eop`.
- `enable` out 1: enable bit for `stream_id`. Held from `load_state` through `eop`.
- `char_in` out 8, `char_in_vld` out 1: character to the matchers.
- `eop` out 1: one-cycle pulse that finalises the packet.
- `pkt_count` out 32: packets completed.
- `proto_err` out 1: sticky. Set when SOP arrives mid-packet.

## Operation
- FSM states: IDLE, LOAD, GAP, STREAM, DRAIN, EOP.
- IDLE: `in_rdy`=0. When `in_vld & in_sop`, latch `in_stream_id`, look up `seen[id]` and `enable_mask[id]`, go to LOAD. The SOP byte is not consumed in IDLE.
- LOAD, one cycle: `load_state`=1 and `new_stream_id`=~seen[id].
- GAP, one cycle: no outputs. This covers the matcher's one-cycle registered restore of `state_in`.
- STREAM: `in_rdy`=1. Each accepted beat drives `char_in`/`char_in_vld` registered on the next cycle. A bubble on `in_vld` gives `char_in_vld`=0. An accepted `in_eop` goes to DRAIN.
- STREAM, non-first beat with `in_sop`=1: set `proto_err`, treat the beat as `in_eop`, and drop its data.
- DRAIN: wait DRAIN_CYCLES cycles counted from the last `char_in_vld`. A 3-bit down-counter is loaded on the `in_eop` accept.
- EOP, one cycle: `eop`=1, `pkt_count`+=1 (wraps at 2^32), and if `enable` then `seen[id]`<=1. Then go to IDLE.
- `stream_id` and `enable` must not change between LOAD and EOP inclusive.
- Config: `cfg_we` acts immediately on the mask. A packet already past IDLE keeps its latched `enable`.
- `cfg_clear_seen` in the same cycle as the EOP seen-write: clear wins.
- Reset values: all outputs 0, `seen` all 0, `enable_mask` all 0, state IDLE.
- Reset mid-packet aborts with no `eop`.

## Timing
- SOP first visible in IDLE at cycle T: `load_state` at T+1, SOP byte accepted at T+3, first `char_in_vld` at T+4.
- Last `char_in_vld` at cycle L: `eop` at L+DRAIN_CYCLES+1.
- Next `load_state` no earlier than the cycle after EOP, so the state_mem write precedes the read.
- Single-byte packet (`in_sop` and `in_eop` on the same beat) is legal. The minimum packet takes 5+DRAIN_CYCLES cycles.
- All outputs are registered, and there is no combinational in-to-out path except `in_rdy`.

## Structure
- Package `dpi_pkg`: the FSM state enum, `SID_W` default, and a `DRAIN_MAX` constant.
- `seen` and `enable_mask` are 2^SID_W-bit flop vectors.
- Natural sub-module: `dpi_stream_table`. It holds the seen/enable storage, the lookup port, the EOP set port, and the config write/clear ports.

## Test plan
- Reset, then a 4-byte packet on stream 5, enabled:
  - `load_state` with `new_stream_id`=1.
  - 4 chars in order, `eop` 3 cycles after the last char.
  - `pkt_count`=1.
  - A second packet on stream 5 gives `new_stream_id`=0.
- Stream 9 disabled: `enable`=0 throughout. After `eop`, `seen[9]` stays 0, so the next packet gives `new_stream_id`=1.
- `in_vld` bubbles mid-packet with 2-cycle gaps: `char_in_vld` shows matching gaps, and `eop` timing is measured from the last char only.
- Single-byte packet with sop=eop: `load_state` at T+1, char at T+4, `eop` at T+7 with DRAIN_CYCLES=2.
- Stray SOP at beat 3: `proto_err`=1, the packet ends with `eop`, 2 chars are emitted, and the next IDLE SOP starts normally.
- Reset asserted during STREAM: no `eop`, all outputs 0 next cycle, and the `seen` table is cleared.
